// File: rtl/adat_frame_deframer_pkg.sv
// Shared ADAT framing constants and types for the deframer.
package adat_frame_deframer_pkg;

    localparam int unsigned ADAT_SYNC_ZEROS     = 10;
    localparam int unsigned ADAT_CHANNELS       = 8;
    localparam int unsigned ADAT_NIBBLES_PER_CH = 6;
    localparam int unsigned ADAT_SAMPLE_W       = 24;
    localparam int unsigned ADAT_USER_W         = 4;
    localparam int unsigned ADAT_NIBBLES        = ADAT_CHANNELS * ADAT_NIBBLES_PER_CH;
    localparam int unsigned ADAT_RUN_W          = 5;
    localparam int unsigned ADAT_RUN_MAX        = 31;
    localparam int unsigned ADAT_NIB_W          = 6;
    localparam int unsigned ADAT_BIT_W          = 3;
    localparam int unsigned ADAT_CH_W           = 3;

    typedef logic [ADAT_SAMPLE_W-1:0] adat_sample_t;
    typedef logic [ADAT_CHANNELS-1:0][ADAT_SAMPLE_W-1:0] adat_samples_t;

    typedef enum logic [1:0] {HUNT, USER, DATA, SYNC} adat_deframe_state_t;

    // One decoded frame as presented downstream.
    typedef struct packed {
        logic [ADAT_USER_W-1:0] user;
        adat_samples_t          samples;
    } adat_frame_t;

endpackage

// File: rtl/adat_frame_deframer_if.sv
// Bit-stream input and decoded-frame output bundle of the deframer.
interface adat_frame_deframer_if;
    import adat_frame_deframer_pkg::*;

    logic                   bit_tick_ni;
    logic                   data_i;
    logic                   valid_i;
    logic                   sync_i;
    logic [ADAT_USER_W-1:0] user_o;
    adat_samples_t          samples_o;
    logic                   frame_valid_o;
    logic                   locked_o;
    logic                   error_o;

    modport master (
        output bit_tick_ni, data_i, valid_i, sync_i,
        input  user_o, samples_o, frame_valid_o, locked_o, error_o
    );

    modport slave (
        input  bit_tick_ni, data_i, valid_i, sync_i,
        output user_o, samples_o, frame_valid_o, locked_o, error_o
    );
endinterface

// File: rtl/adat_frame_deframer_sync_detector.sv
// Zero-run counter with sync-hit and run-overflow flags.
module adat_frame_deframer_sync_detector
    import adat_frame_deframer_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = ADAT_SYNC_ZEROS
) (
    input  logic clk_x4_i,
    input  logic rst_ni,
    input  logic i_bit_en,
    input  logic i_bit,
    input  logic i_clear,
    output logic o_sync_hit_c,
    output logic o_run_overflow_c
);

    logic [ADAT_RUN_W-1:0] r_run;

    // Count consecutive zero bits, saturating; a one bit or loss of lock clears it.
    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_run <= '0;
        end else if (i_clear) begin
            r_run <= '0;
        end else if (i_bit_en) begin
            if (i_bit) begin
                r_run <= '0;
            end else if (r_run != ADAT_RUN_W'(ADAT_RUN_MAX)) begin
                r_run <= r_run + ADAT_RUN_W'(1);
            end
        end
    end

    assign o_sync_hit_c     = i_bit_en && i_bit && (r_run >= ADAT_RUN_W'(SYNC_MIN_ZEROS));
    assign o_run_overflow_c = i_bit_en && !i_bit && (r_run == ADAT_RUN_W'(ADAT_RUN_MAX - 1));

endmodule

// File: rtl/adat_frame_deframer.sv
// ADAT deframer: finds sync, strips separators, presents each full frame with a strobe.
module adat_frame_deframer
    import adat_frame_deframer_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES    = 3,
    parameter int unsigned SYNC_MIN_ZEROS = ADAT_SYNC_ZEROS
) (
    input  logic                  clk_x4_i,
    input  logic                  rst_ni,
    adat_frame_deframer_if.slave  adat
);

    localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);

    adat_deframe_state_t    r_state;
    adat_deframe_state_t    w_state_nxt;
    logic [ADAT_BIT_W-1:0]  r_user_cnt;
    logic [ADAT_BIT_W-1:0]  r_bit_cnt;
    logic [ADAT_NIB_W-1:0]  r_nib_cnt;
    logic [ADAT_USER_W-1:0] r_user_sh;
    adat_samples_t          r_shadow;
    adat_frame_t            r_out;
    logic                   r_frame_valid;
    logic                   r_error;
    logic                   r_locked;
    logic [GOOD_W-1:0]      r_good;

    logic                   w_bit;
    logic                   w_drop;
    logic                   w_d;
    logic                   w_sync_hit;
    logic                   w_overflow;
    logic [ADAT_CH_W-1:0]   w_ch;
    logic                   w_enter_user_c;
    logic                   w_user_shift_c;
    logic                   w_data_shift_c;
    logic                   w_nib_done_c;
    logic                   w_commit_c;
    logic                   w_error_c;

    assign w_bit  = !adat.bit_tick_ni && adat.valid_i && adat.sync_i;
    assign w_drop = !adat.sync_i || (!adat.bit_tick_ni && !adat.valid_i);
    assign w_d    = adat.data_i;
    assign w_ch   = ADAT_CH_W'(r_nib_cnt / ADAT_NIB_W'(ADAT_NIBBLES_PER_CH));

    adat_frame_deframer_sync_detector #(
        .SYNC_MIN_ZEROS (SYNC_MIN_ZEROS)
    ) u_sync_detector (
        .clk_x4_i         (clk_x4_i),
        .rst_ni           (rst_ni),
        .i_bit_en         (w_bit),
        .i_bit            (w_d),
        .i_clear          (w_drop),
        .o_sync_hit_c     (w_sync_hit),
        .o_run_overflow_c (w_overflow)
    );

    // State register.
    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= HUNT;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; loss of decoder lock or an invalid tick forces HUNT.
    always_comb begin
        w_state_nxt = r_state;
        if (w_drop) begin
            w_state_nxt = HUNT;
        end else if (w_bit) begin
            case (r_state)
                HUNT: if (w_sync_hit) w_state_nxt = USER;
                USER: if (r_user_cnt == ADAT_BIT_W'(ADAT_USER_W)) w_state_nxt = w_d ? DATA : HUNT;
                DATA: begin
                    if (r_bit_cnt == ADAT_BIT_W'(4)) begin
                        if (!w_d)                                        w_state_nxt = HUNT;
                        else if (r_nib_cnt == ADAT_NIB_W'(ADAT_NIBBLES - 1)) w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (w_d)             w_state_nxt = w_sync_hit ? USER : HUNT;
                    else if (w_overflow) w_state_nxt = HUNT;
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Per-bit control decode: shifts, separator checks, commit and error strobes.
    always_comb begin
        w_enter_user_c = 1'b0;
        w_user_shift_c = 1'b0;
        w_data_shift_c = 1'b0;
        w_nib_done_c   = 1'b0;
        w_commit_c     = 1'b0;
        w_error_c      = 1'b0;
        if (w_bit) begin
            case (r_state)
                HUNT: w_enter_user_c = w_sync_hit;
                USER: begin
                    if (r_user_cnt != ADAT_BIT_W'(ADAT_USER_W)) w_user_shift_c = 1'b1;
                    else                                        w_error_c      = !w_d;
                end
                DATA: begin
                    if (r_bit_cnt != ADAT_BIT_W'(4)) begin
                        w_data_shift_c = 1'b1;
                    end else begin
                        w_error_c    = !w_d;
                        w_nib_done_c = w_d;
                        w_commit_c   = w_d && (r_nib_cnt == ADAT_NIB_W'(ADAT_NIBBLES - 1));
                    end
                end
                SYNC: begin
                    if (w_d) begin
                        w_enter_user_c = w_sync_hit;
                        w_error_c      = !w_sync_hit;
                    end else begin
                        w_error_c      = w_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow shift registers and bit/nibble counters for the frame in progress.
    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_user_cnt <= '0;
            r_bit_cnt  <= '0;
            r_nib_cnt  <= '0;
            r_user_sh  <= '0;
            r_shadow   <= '0;
        end else begin
            if (w_enter_user_c) begin
                r_user_cnt <= '0;
                r_bit_cnt  <= '0;
                r_nib_cnt  <= '0;
            end
            if (w_user_shift_c) begin
                r_user_sh  <= {r_user_sh[ADAT_USER_W-2:0], w_d};
                r_user_cnt <= r_user_cnt + ADAT_BIT_W'(1);
            end
            if (w_data_shift_c) begin
                r_shadow[w_ch] <= {r_shadow[w_ch][ADAT_SAMPLE_W-2:0], w_d};
                r_bit_cnt      <= r_bit_cnt + ADAT_BIT_W'(1);
            end
            if (w_nib_done_c) begin
                r_bit_cnt <= '0;
                r_nib_cnt <= r_nib_cnt + ADAT_NIB_W'(1);
            end
        end
    end

    // Output frame, strobes and lock tracking.
    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out         <= '0;
            r_frame_valid <= 1'b0;
            r_error       <= 1'b0;
            r_locked      <= 1'b0;
            r_good        <= '0;
        end else begin
            r_frame_valid <= w_commit_c;
            r_error       <= w_error_c;
            if (w_commit_c) begin
                r_out.user    <= r_user_sh;
                r_out.samples <= r_shadow;
            end
            if (w_error_c || w_drop) begin
                r_good   <= '0;
                r_locked <= 1'b0;
            end else begin
                if (w_commit_c && (r_good != GOOD_W'(LOCK_FRAMES))) r_good <= r_good + GOOD_W'(1);
                r_locked <= (r_good == GOOD_W'(LOCK_FRAMES));
            end
        end
    end

    assign adat.user_o        = r_out.user;
    assign adat.samples_o     = r_out.samples;
    assign adat.frame_valid_o = r_frame_valid;
    assign adat.error_o       = r_error;
    assign adat.locked_o      = r_locked;

endmodule

// File: tb/tb_adat_frame_deframer.sv
// Directed bench for the ADAT deframer.
module tb_adat_frame_deframer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   jitter = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_fv = 0;
    int   n_epulse = 0;
    int   fv0;
    int   e0;
    logic [7:0][23:0] exp_s;
    logic [3:0]       exp_user;

    adat_frame_deframer_if bus ();

    adat_frame_deframer dut (
        .clk_x4_i (clk),
        .rst_ni   (rst_n),
        .adat     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid_o === 1'b1) n_fv++;
        if (bus.error_o === 1'b1)       n_epulse++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one tick and return on the following negedge, when its effects are visible.
    task automatic send_bit(input logic b, input logic v);
        @(negedge clk);
        bus.bit_tick_ni = 1'b0;
        bus.data_i      = b;
        bus.valid_i     = v;
        @(negedge clk);
        bus.bit_tick_ni = 1'b1;
        bus.valid_i     = 1'b1;
    endtask

    task automatic idle_gap();
        int g;
        g = jitter ? int'($urandom_range(3, 1)) : 2;
        repeat (g) @(negedge clk);
    endtask

    task automatic bitx(input logic b);
        send_bit(b, 1'b1);
        idle_gap();
    endtask

    // Whole frame except the final separator; optional fault injections by nibble index.
    task automatic send_frame(input int zeros, input int bad_nib, input int drop_nib,
                              input int abort_nib, input logic sync_err);
        logic [23:0] s;
        for (int i = 0; i < zeros; i++) bitx(1'b0);
        send_bit(1'b1, 1'b1);
        chk("sync_error", 192'(bus.error_o), 192'(sync_err));
        idle_gap();
        for (int i = 3; i >= 0; i--) bitx(exp_user[i]);
        bitx(1'b1);
        for (int nib = 0; nib < 48; nib++) begin
            if (nib == abort_nib) return;
            if (nib == drop_nib) begin
                send_bit(1'b0, 1'b0);
                chk("drop_locked", 192'(bus.locked_o), 192'(0));
                chk("drop_error", 192'(bus.error_o), 192'(0));
                idle_gap();
            end
            s = exp_s[nib / 6];
            for (int b = 0; b < 4; b++) bitx(s[23 - 4 * (nib % 6) - b]);
            if (nib == 47) return;
            if (nib == bad_nib) begin
                send_bit(1'b0, 1'b1);
                chk("sep_error", 192'(bus.error_o), 192'(1));
                chk("sep_locked", 192'(bus.locked_o), 192'(0));
                idle_gap();
            end else begin
                bitx(1'b1);
            end
        end
    endtask

    // Final separator with strobe latency and lock checks.
    task automatic last_sep(input logic fv, input logic lk1, input logic lk2);
        send_bit(1'b1, 1'b1);
        chk("fv_strobe", 192'(bus.frame_valid_o), 192'(fv));
        chk("locked_at_strobe", 192'(bus.locked_o), 192'(lk1));
        @(negedge clk);
        chk("fv_one_cycle", 192'(bus.frame_valid_o), 192'(0));
        chk("locked_after_strobe", 192'(bus.locked_o), 192'(lk2));
        idle_gap();
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_user"}, 192'(bus.user_o), 192'(exp_user));
        chk({tag, "_samples"}, 192'(bus.samples_o), 192'(exp_s));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_user"}, 192'(bus.user_o), 192'(0));
        chk({tag, "_samples"}, 192'(bus.samples_o), 192'(0));
        chk({tag, "_fv"}, 192'(bus.frame_valid_o), 192'(0));
        chk({tag, "_locked"}, 192'(bus.locked_o), 192'(0));
        chk({tag, "_error"}, 192'(bus.error_o), 192'(0));
    endtask

    initial begin
        exp_user = 4'hA;
        for (int n = 0; n < 8; n++) exp_s[n] = 24'(32'h100000 * n + 32'h0ABCDE);
        bus.bit_tick_ni = 1'b1;
        bus.data_i      = 1'b0;
        bus.valid_i     = 1'b1;
        bus.sync_i      = 1'b1;

        // Reset values
        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Three legal frames, lock after the third
        fv0 = n_fv; e0 = n_epulse;
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        chk_frame("f1");
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b1);
        chk_frame("f3");
        chk("t1_strobes", 192'(n_fv - fv0), 192'(3));
        chk("t1_errors", 192'(n_epulse - e0), 192'(0));

        // Jittered tick spacing
        jitter = 1'b1;
        fv0 = n_fv; e0 = n_epulse;
        for (int f = 0; f < 3; f++) begin
            send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b1, 1'b1);
        end
        chk_frame("jit");
        chk("t2_strobes", 192'(n_fv - fv0), 192'(3));
        chk("t2_errors", 192'(n_epulse - e0), 192'(0));
        jitter = 1'b0;

        // Separator of nibble 20 forced low
        fv0 = n_fv; e0 = n_epulse;
        send_frame(10, 20, -1, -1, 1'b0); last_sep(1'b0, 1'b0, 1'b0);
        chk_frame("badsep_hold");
        chk("t3_strobes", 192'(n_fv - fv0), 192'(0));
        chk("t3_errors", 192'(n_epulse - e0), 192'(1));

        // Short sync: 9 zeros while in SYNC
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        fv0 = n_fv; e0 = n_epulse;
        send_frame(9, -1, -1, -1, 1'b1); last_sep(1'b0, 1'b0, 1'b0);
        chk("t4_errors", 192'(n_epulse - e0), 192'(1));
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        chk("t4_strobes", 192'(n_fv - fv0), 192'(1));

        // Invalid tick mid-frame while locked
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b1);
        fv0 = n_fv; e0 = n_epulse;
        send_frame(10, -1, 10, -1, 1'b0); last_sep(1'b0, 1'b0, 1'b0);
        chk("t5_errors", 192'(n_epulse - e0), 192'(0));
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        chk("t5_strobes", 192'(n_fv - fv0), 192'(1));

        // Decoder lock lost mid-frame clears the good-frame count
        e0 = n_epulse;
        send_frame(10, -1, -1, 7, 1'b0);
        @(negedge clk); bus.sync_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("synclow_locked", 192'(bus.locked_o), 192'(0));
        bus.sync_i = 1'b1;
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        send_frame(10, -1, -1, -1, 1'b0); last_sep(1'b1, 1'b0, 1'b0);
        chk("synclow_errors", 192'(n_epulse - e0), 192'(0));

        // Asynchronous reset mid-DATA
        send_frame(10, -1, -1, 12, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        fv0 = n_fv;
        send_frame(10, -1, -1, -1, 1'b0);
        chk("reset_no_early_fv", 192'(n_fv - fv0), 192'(0));
        last_sep(1'b1, 1'b0, 1'b0);
        chk_frame("after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
